// File: rtl/dmem_responder_pkg.sv
// =============================================================================
// riscv_types: memory-op and responder-state types shared by the dmem blocks.
// Rev 1.0
// =============================================================================
`default_nettype none

package riscv_types;

   localparam int unsigned DMEM_CNT_W = 4;

   typedef enum logic [2:0] {
      MEM_B  = 3'b000,
      MEM_H  = 3'b001,
      MEM_W  = 3'b010,
      MEM_BU = 3'b100,
      MEM_HU = 3'b101
   } mem_op_t;

   typedef enum logic [0:0] {
      DMEM_IDLE = 1'b0,
      DMEM_BUSY = 1'b1
   } dmem_state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_responder_align.sv
// =============================================================================
// lsu_align: byte-lane steering for stores and sign/zero extension for loads.
// Rev 1.0
// =============================================================================
`default_nettype none

module lsu_align
   import riscv_types::*;
(
   input  logic [2:0]  op_i,
   input  logic [1:0]  addr_lo_i,
   input  logic        is_store_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rword_i,
   output logic [3:0]  byte_en_o,
   output logic [31:0] wword_o,
   output logic [31:0] rdata_o,
   output logic        misaligned_o,
   output logic        illegal_o
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   assign ld_byte = rword_i[{addr_lo_i, 3'b000} +: 8];
   assign ld_half = rword_i[{addr_lo_i[1], 4'b0000} +: 16];

   always_comb begin
      byte_en_o    = 4'b0000;
      wword_o      = 32'h0;
      rdata_o      = 32'h0;
      misaligned_o = 1'b0;
      illegal_o    = 1'b0;
      case (op_i)
         MEM_B, MEM_BU: begin
            byte_en_o = 4'b0001 << addr_lo_i;
            wword_o   = {4{wdata_i[7:0]}};
            rdata_o   = (op_i == MEM_B) ? {{24{ld_byte[7]}}, ld_byte}
                                        : {24'h0, ld_byte};
         end
         MEM_H, MEM_HU: begin
            byte_en_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            wword_o      = {2{wdata_i[15:0]}};
            rdata_o      = (op_i == MEM_H) ? {{16{ld_half[15]}}, ld_half}
                                           : {16'h0, ld_half};
            misaligned_o = addr_lo_i[0];
         end
         MEM_W: begin
            byte_en_o    = 4'b1111;
            wword_o      = wdata_i;
            rdata_o      = rword_i;
            misaligned_o = |addr_lo_i;
         end
         default: illegal_o = 1'b1;
      endcase
      // Unsigned variants only make sense for loads.
      if (is_store_i && op_i[2]) begin
         illegal_o = 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// =============================================================================
// dmem_responder: MEM-stage data-memory target with optional wait states.
// Rev 1.0
// =============================================================================
`default_nettype none

module dmem_responder
   import riscv_types::*;
#(
   parameter int unsigned DMEM_DEPTH  = 1024,
   parameter int unsigned WAIT_STATES = 0
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] mem_addr_mem,
   input  logic [31:0] mem_wdata_mem,
   input  logic [2:0]  mem_op_mem,
   input  logic        mem_write_mem,
   input  logic        mem_to_reg_mem,
   output logic [31:0] mem_rdata_mem,
   output logic        mem_stall,
   output logic        mem_err
);

   localparam int unsigned IDX_W = $clog2(DMEM_DEPTH);

   logic [31:0]      mem_q [DMEM_DEPTH];
   logic [31:0]      rdata_q, rdata_d;
   logic             err_q, err_d;

   logic [31:0]      acc_addr;
   logic [31:0]      acc_wdata;
   logic [2:0]       acc_op;
   logic             acc_wr;
   logic             acc_rd;
   logic             acc_fire;

   logic [IDX_W-1:0] idx;
   logic             out_of_range;
   logic [31:0]      rword;
   logic [3:0]       byte_en;
   logic [31:0]      wword;
   logic [31:0]      ld_ext;
   logic             misaligned;
   logic             illegal;
   logic             access_bad;
   logic             store_en;
   logic             load_done;

   if (WAIT_STATES == 0) begin : g_no_wait
      assign acc_addr  = mem_addr_mem;
      assign acc_wdata = mem_wdata_mem;
      assign acc_op    = mem_op_mem;
      assign acc_wr    = mem_write_mem;
      assign acc_rd    = mem_to_reg_mem;
      assign acc_fire  = mem_write_mem | mem_to_reg_mem;
      assign mem_stall = 1'b0;
   end else begin : g_wait
      localparam logic [DMEM_CNT_W-1:0] CNT_INIT = DMEM_CNT_W'(WAIT_STATES - 1);

      dmem_state_t           state_q, state_d;
      logic [DMEM_CNT_W-1:0] cnt_q, cnt_d;
      logic [31:0]           addr_q, wdata_q;
      logic [2:0]            op_q;
      logic                  wr_q, rd_q;
      logic                  capture;
      logic                  fire;
      logic                  stall;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            state_q <= DMEM_IDLE;
            cnt_q   <= '0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            op_q    <= 3'b000;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
               addr_q  <= mem_addr_mem;
               wdata_q <= mem_wdata_mem;
               op_q    <= mem_op_mem;
               wr_q    <= mem_write_mem;
               rd_q    <= mem_to_reg_mem;
            end
         end
      end

      // The completion cycle drops stall but deliberately ignores the request
      // still on the bus: it is the same access, released by the pipeline now.
      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         capture = 1'b0;
         fire    = 1'b0;
         stall   = 1'b0;
         case (state_q)
            DMEM_IDLE: begin
               if (mem_write_mem || mem_to_reg_mem) begin
                  stall   = 1'b1;
                  capture = 1'b1;
                  cnt_d   = CNT_INIT;
                  state_d = DMEM_BUSY;
               end
            end
            DMEM_BUSY: begin
               if (cnt_q != '0) begin
                  stall = 1'b1;
                  cnt_d = cnt_q - 1'b1;
               end else begin
                  fire    = 1'b1;
                  state_d = DMEM_IDLE;
               end
            end
            default: state_d = DMEM_IDLE;
         endcase
      end

      assign acc_addr  = addr_q;
      assign acc_wdata = wdata_q;
      assign acc_op    = op_q;
      assign acc_wr    = wr_q;
      assign acc_rd    = rd_q;
      assign acc_fire  = fire;
      assign mem_stall = stall;
   end

   assign idx          = acc_addr[IDX_W+1:2];
   assign out_of_range = |acc_addr[31:IDX_W+2];
   assign rword        = mem_q[idx];

   lsu_align u_align (
      .op_i         (acc_op),
      .addr_lo_i    (acc_addr[1:0]),
      .is_store_i   (acc_wr),
      .wdata_i      (acc_wdata),
      .rword_i      (rword),
      .byte_en_o    (byte_en),
      .wword_o      (wword),
      .rdata_o      (ld_ext),
      .misaligned_o (misaligned),
      .illegal_o    (illegal)
   );

   // A both-high request is treated as a store; it still flags an error.
   assign access_bad = out_of_range | misaligned | illegal;
   assign store_en   = acc_fire & acc_wr & ~access_bad;
   assign load_done  = acc_fire & acc_rd & ~acc_wr;
   assign err_d      = acc_fire & (access_bad | (acc_wr & acc_rd));
   assign rdata_d    = load_done ? (access_bad ? 32'h0 : ld_ext) : rdata_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (store_en) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) begin
               mem_q[idx][8*b +: 8] <= wword[8*b +: 8];
            end
         end
      end
   end

   assign mem_rdata_mem = rdata_q;
   assign mem_err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// =============================================================================
// tb_dmem_responder: zero-wait and three-wait responders against a bench model.
// Rev 1.0
// =============================================================================
`default_nettype none

module tb_dmem_responder;

   localparam int DEPTH = 1024;
   localparam int NWAIT = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic [31:0] a0 = '0, d0 = '0, a3 = '0, d3 = '0;
   logic [2:0]  o0 = '0, o3 = '0;
   logic        w0 = 0, r0 = 0, w3 = 0, r3 = 0;
   logic [31:0] rd0, rd3;
   logic        st0, st3, er0, er3;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DMEM_DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
      .clk(clk), .reset(rst), .mem_addr_mem(a0), .mem_wdata_mem(d0), .mem_op_mem(o0),
      .mem_write_mem(w0), .mem_to_reg_mem(r0), .mem_rdata_mem(rd0), .mem_stall(st0),
      .mem_err(er0));

   dmem_responder #(.DMEM_DEPTH(DEPTH), .WAIT_STATES(NWAIT)) u_dut3 (
      .clk(clk), .reset(rst), .mem_addr_mem(a3), .mem_wdata_mem(d3), .mem_op_mem(o3),
      .mem_write_mem(w3), .mem_to_reg_mem(r3), .mem_rdata_mem(rd3), .mem_stall(st3),
      .mem_err(er3));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Access semantics from first principles: size, lane, range, sign rules.
   function automatic void mdl_exec(input logic [31:0] addr, input logic [31:0] wdata,
                                    input logic [2:0] op, input bit is_st,
                                    input logic [31:0] old, output bit wen,
                                    output logic [31:0] neww, output logic [31:0] ldata,
                                    output bit bad);
      int size, lane;
      logic [31:0] v, mask;
      lane = int'(addr % 4);
      case (int'(op) % 4)
         0:       size = 1;
         1:       size = 2;
         default: size = 4;
      endcase
      bad = (addr >= 32'(4 * DEPTH)) || (op == 3'd3) || (op >= 3'd6) ||
            (is_st && op >= 3'd4) || (lane % size != 0);
      neww = old;
      for (int i = 0; i < size; i++)
         if (lane + i < 4) neww[8*(lane+i) +: 8] = wdata[8*i +: 8];
      wen  = is_st && !bad;
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 1);
      v    = (old >> (8 * lane)) & mask;
      if (op < 3'd4 && size < 4 && v[8*size-1]) v = v | ~mask;
      ldata = bad ? 32'h0 : v;
   endfunction

   logic [31:0] m0 [DEPTH];
   logic [31:0] m3 [DEPTH];
   logic [31:0] e0_rdata = '0, e3_rdata = '0;
   bit          e0_err = 0, e3_err = 0;
   int          left3 = 0;
   logic [31:0] c_a = '0, c_d = '0;
   logic [2:0]  c_o = '0;
   bit          c_w = 0, c_r = 0;

   always @(posedge clk or posedge rst) begin : model0
      bit wen, bad;
      logic [31:0] nw, ld;
      if (rst) begin
         e0_rdata = '0;
         e0_err   = 0;
      end else begin
         e0_err = 0;
         if (w0 || r0) begin
            mdl_exec(a0, d0, o0, w0, m0[int'(a0[11:2])], wen, nw, ld, bad);
            if (wen) m0[int'(a0[11:2])] = nw;
            if (r0 && !w0) e0_rdata = ld;
            e0_err = bad || (w0 && r0);
         end
      end
   end

   // Zero-wait behaviour delayed: N stall cycles, then one completion cycle.
   always @(posedge clk or posedge rst) begin : model3
      bit wen, bad;
      logic [31:0] nw, ld;
      if (rst) begin
         e3_rdata = '0;
         e3_err   = 0;
         left3    = 0;
      end else begin
         e3_err = 0;
         if (left3 == 1) begin
            mdl_exec(c_a, c_d, c_o, c_w, m3[int'(c_a[11:2])], wen, nw, ld, bad);
            if (wen) m3[int'(c_a[11:2])] = nw;
            if (c_r && !c_w) e3_rdata = ld;
            e3_err = bad || (c_w && c_r);
            left3  = 0;
         end else if (left3 > 1) begin
            left3--;
         end else if (w3 || r3) begin
            c_a = a3; c_d = d3; c_o = o3; c_w = w3; c_r = r3;
            left3 = NWAIT;
         end
      end
   end

   always @(negedge clk) begin : compare
      chk("cmp0_rdata", rd0, e0_rdata);
      chk("cmp0_err",   32'(er0), 32'(e0_err));
      chk("cmp0_stall", 32'(st0), 32'd0);
      chk("cmp3_rdata", rd3, e3_rdata);
      chk("cmp3_err",   32'(er3), 32'(e3_err));
      chk("cmp3_stall", 32'(st3), 32'(((left3 == 0) && (w3 || r3)) || (left3 > 1)));
   end

   task automatic acc0(input bit wr, input bit rd, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] d);
      w0 = wr; r0 = rd; o0 = op; a0 = a; d0 = d;
      @(posedge clk); #1;
      w0 = 0; r0 = 0;
   endtask

   task automatic acc3(input bit wr, input bit rd, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] d, output int stalls);
      bit s, done;
      w3 = wr; r3 = rd; o3 = op; a3 = a; d3 = d;
      stalls = 0;
      done   = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk); s = st3;
         @(posedge clk); #1;
         if (s) stalls++;
         else done = 1;
      end
      w3 = 0; r3 = 0;
      if (!done) chk("acc3_timeout", 32'd0, 32'd1);
   endtask

   initial begin : timeout
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1);
   end

   initial begin : stim
      int ns;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      chk("reset_rdata0", rd0, 32'h0);
      chk("reset_err3",   32'(er3), 32'd0);
      chk("reset_stall3", 32'(st3), 32'd0);

      acc0(1, 0, 3'b010, 32'h10, 32'hDEADBEEF);
      acc0(0, 1, 3'b010, 32'h10, 32'h0);
      chk("lw_10", rd0, 32'hDEADBEEF);
      acc0(1, 0, 3'b000, 32'h11, 32'h0000_0080);
      chk("sb_holds_rdata", rd0, 32'hDEADBEEF);
      acc0(0, 1, 3'b000, 32'h11, 32'h0);
      chk("lb_11", rd0, 32'hFFFFFF80);
      acc0(0, 1, 3'b100, 32'h11, 32'h0);
      chk("lbu_11", rd0, 32'h00000080);
      acc0(0, 1, 3'b010, 32'h10, 32'h0);
      chk("lw_after_sb", rd0, 32'hDEAD80EF);

      acc0(1, 0, 3'b001, 32'h13, 32'h0000_1234);
      chk("sh_mis_err", 32'(er0), 32'd1);
      @(posedge clk); #1;
      chk("err_one_cycle", 32'(er0), 32'd0);
      acc0(0, 1, 3'b010, 32'h10, 32'h0);
      chk("word_unchanged", rd0, 32'hDEAD80EF);
      acc0(0, 1, 3'b010, 32'h12, 32'h0);
      chk("lw_mis_rdata", rd0, 32'h0);
      chk("lw_mis_err", 32'(er0), 32'd1);
      acc0(0, 1, 3'b001, 32'h12, 32'h0);
      chk("lh_12", rd0, 32'hFFFFDEAD);
      acc0(0, 1, 3'b101, 32'h12, 32'h0);
      chk("lhu_12", rd0, 32'h0000DEAD);
      acc0(0, 1, 3'b011, 32'h10, 32'h0);
      chk("illegal_op_err", 32'(er0), 32'd1);
      acc0(1, 0, 3'b100, 32'h10, 32'h0000_0055);
      chk("store_bu_err", 32'(er0), 32'd1);

      acc0(1, 0, 3'b010, 32'h0, 32'h12345678);
      acc0(1, 0, 3'b010, 32'h1000, 32'hAAAAAAAA);
      chk("oor_err", 32'(er0), 32'd1);
      acc0(0, 1, 3'b010, 32'h0, 32'h0);
      chk("oor_no_alias", rd0, 32'h12345678);
      acc0(1, 1, 3'b010, 32'h4, 32'hCAFEF00D);
      chk("both_err", 32'(er0), 32'd1);
      chk("both_rdata_hold", rd0, 32'h12345678);
      acc0(0, 1, 3'b010, 32'h4, 32'h0);
      chk("both_stored", rd0, 32'hCAFEF00D);

      acc3(1, 0, 3'b010, 32'h20, 32'h11111111, ns);
      chk("w3_sw_stalls", 32'(ns), 32'd3);
      acc3(0, 1, 3'b010, 32'h20, 32'h0, ns);
      chk("w3_lw_stalls", 32'(ns), 32'd3);
      chk("w3_lw_data", rd3, 32'h11111111);
      @(posedge clk); #1;
      chk("w3_no_reaccept", 32'(st3), 32'd0);
      acc3(0, 1, 3'b100, 32'h23, 32'h0, ns);
      chk("w3_lbu_data", rd3, 32'h00000011);

      w3 = 1; o3 = 3'b010; a3 = 32'h20; d3 = 32'h22222222;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1; w3 = 0;
      #1 chk("rst_stall3", 32'(st3), 32'd0);
      @(posedge clk); #1;
      rst = 0;
      chk("rst_rdata3", rd3, 32'h0);
      acc3(0, 1, 3'b010, 32'h20, 32'h0, ns);
      chk("rst_drops_store", rd3, 32'h11111111);
      repeat (2) @(posedge clk);
      #1;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
